// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Result stage behind the 16-bit ALU. Each ALU operation delivers
// {OUT, Cout, overflow, lt, gt, eq, opcod} plus a destination tag. The stage:
//   - buffers results in a 2-entry valid/ready FIFO toward write-back,
//   - holds the architectural status flags {C,V,N,Z,LT,GT,EQ}, updated only
//     when an entry retires (pops),
//   - keeps a sticky signed-overflow bit,
//   - evaluates a branch condition against the registered flags.
//
// Optional feature macro: ALU_RESULT_PERF_CNT_EN
//   When defined, adds retire_cnt[15:0] (wrapping pop counter) and
//   stall_cnt[15:0] (saturating count of cycles with in_valid & !in_ready).
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   producer handshake (in_ready = FIFO not full)
//   in_data..in_dest    ALU result fields for one operation
//   out_valid/out_ready write-back handshake (out_valid = FIFO not empty)
//   out_data, out_dest  head entry (data forced to 0 for ops 110/111)
//   flags               {C,V,N,Z,LT,GT,EQ} registered status
//   sticky_ovf          sticky overflow, cleared by sticky_clr
//   illegal_op          1-cycle pulse after an op 110/111 retires
//   br_cond, br_taken   branch condition select and its evaluation
//   retire_cnt, stall_cnt  (macro only) performance counters
// ---------------------------------------------------------------------------
module alu_result_stage #(
   parameter int DEST_W = 4,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_data,
   input  logic              in_cout,
   input  logic              in_ovf,
   input  logic              in_lt,
   input  logic              in_gt,
   input  logic              in_eq,
   input  logic [2:0]        in_op,
   input  logic [DEST_W-1:0] in_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_data,
   output logic [DEST_W-1:0] out_dest,
   output logic [6:0]        flags,
   output logic              sticky_ovf,
   input  logic              sticky_clr,
   output logic              illegal_op,
   input  logic [2:0]        br_cond,
`ifdef ALU_RESULT_PERF_CNT_EN
   output logic [15:0]       retire_cnt,
   output logic [15:0]       stall_cnt,
`endif
   output logic              br_taken
);

   // flag bit positions within flags
   localparam int F_C  = 6;
   localparam int F_V  = 5;
   localparam int F_N  = 4;
   localparam int F_Z  = 3;
   localparam int F_LT = 2;
   localparam int F_GT = 1;
   localparam int F_EQ = 0;

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   typedef struct packed {
      logic [15:0]       data;
      logic              cout;
      logic              ovf;
      logic              lt;
      logic              gt;
      logic              eq;
      logic [2:0]        op;
      logic [DEST_W-1:0] dest;
   } entry_t;

   entry_t            mem [0:1];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              push;
   logic              pop;
   entry_t            head;
   entry_t            in_entry;
   logic              head_illegal;
   logic              head_ovf_op;
   logic [6:0]        flags_nxt;
   logic [15:0]       hold_data;
   logic [DEST_W-1:0] hold_dest;

   // ---------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------
   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign in_entry = '{data: in_data, cout: in_cout, ovf: in_ovf,
                       lt: in_lt, gt: in_gt, eq: in_eq,
                       op: in_op, dest: in_dest};

   assign head         = mem[rd_ptr];
   assign head_illegal = (head.op[2:1] == 2'b11);
   assign head_ovf_op  = (head.op == 3'b011) || (head.op == 3'b100);

   // Entry storage carries no reset; it is only observed while count != 0.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_entry;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         // push and pop together leave count unchanged
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output view. While empty, present the last retired values so the
   // write-back side sees stable data rather than stale storage.
   // ---------------------------------------------------------------------
   always_comb begin
      out_data = hold_data;
      out_dest = hold_dest;
      if (out_valid) begin
         out_data = head_illegal ? 16'h0000 : head.data;
         out_dest = head.dest;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_data <= 16'h0000;
         hold_dest <= '0;
      end else if (pop) begin
         hold_data <= out_data;
         hold_dest <= out_dest;
      end
   end

   // ---------------------------------------------------------------------
   // Flag decode of the head entry, applied only on retire.
   // ---------------------------------------------------------------------
   always_comb begin
      flags_nxt = flags;
      case (head.op)
         3'b000, 3'b001: begin
            flags_nxt[F_N]  = head.data[15];
            flags_nxt[F_Z]  = (head.data == 16'h0000);
            flags_nxt[F_LT] = head.lt;
            flags_nxt[F_GT] = head.gt;
            flags_nxt[F_EQ] = head.eq;
         end
         3'b010: begin
            flags_nxt[F_C]  = head.cout;
            flags_nxt[F_N]  = head.data[15];
            flags_nxt[F_Z]  = (head.data == 16'h0000);
            flags_nxt[F_LT] = head.lt;
            flags_nxt[F_GT] = head.gt;
            flags_nxt[F_EQ] = head.eq;
         end
         3'b011, 3'b100: begin
            flags_nxt[F_C]  = head.cout;
            flags_nxt[F_V]  = head.ovf;
            flags_nxt[F_N]  = head.data[15];
            flags_nxt[F_Z]  = (head.data == 16'h0000);
            flags_nxt[F_LT] = head.lt;
            flags_nxt[F_GT] = head.gt;
            flags_nxt[F_EQ] = head.eq;
         end
         3'b101: begin
            flags_nxt[F_Z]  = (head.data == 16'h0000);
            flags_nxt[F_LT] = head.lt;
            flags_nxt[F_GT] = head.gt;
            flags_nxt[F_EQ] = head.eq;
         end
         default: flags_nxt = flags;   // 110/111: no flag change
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags      <= 7'b0;
         sticky_ovf <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         if (pop) flags <= flags_nxt;
         illegal_op <= pop & head_illegal;
         // set has priority over a simultaneous clear
         if (pop && head_ovf_op && head.ovf) sticky_ovf <= 1'b1;
         else if (sticky_clr)                 sticky_ovf <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Branch evaluation: registered flags only, so a branch in the retire
   // cycle sees the pre-retire state.
   // ---------------------------------------------------------------------
   always_comb begin
      case (br_cond)
         3'b000:  br_taken = 1'b0;
         3'b001:  br_taken = 1'b1;
         3'b010:  br_taken = flags[F_EQ];
         3'b011:  br_taken = ~flags[F_EQ];
         3'b100:  br_taken = flags[F_LT];
         3'b101:  br_taken = ~flags[F_LT];
         3'b110:  br_taken = flags[F_GT];
         default: br_taken = ~flags[F_GT];
      endcase
   end

`ifdef ALU_RESULT_PERF_CNT_EN
   // ---------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_cnt <= 16'h0000;
         stall_cnt  <= 16'h0000;
      end else begin
         if (pop) retire_cnt <= retire_cnt + 16'd1;   // wraps naturally
         if (in_valid && !in_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage: directed self-checking bench for alu_result_stage.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_cout, in_ovf, in_lt, in_gt, in_eq;
   logic [2:0]  in_op;
   logic [3:0]  in_dest;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_dest;
   logic [6:0]  flags;
   logic        sticky_ovf;
   logic        sticky_clr;
   logic        illegal_op;
   logic [2:0]  br_cond;
   logic        br_taken;
`ifdef ALU_RESULT_PERF_CNT_EN
   logic [15:0] retire_cnt;
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.DEST_W(4), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_cout(in_cout), .in_ovf(in_ovf),
      .in_lt(in_lt), .in_gt(in_gt), .in_eq(in_eq),
      .in_op(in_op), .in_dest(in_dest),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_dest(out_dest),
      .flags(flags), .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
      .illegal_op(illegal_op), .br_cond(br_cond),
`ifdef ALU_RESULT_PERF_CNT_EN
      .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
`endif
      .br_taken(br_taken)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // stimulus only: load the ALU-side input fields
   task automatic set_in(input logic v, input logic [2:0] op, input logic [15:0] d,
                         input logic c, input logic o, input logic lt,
                         input logic gt, input logic eq, input logic [3:0] dst);
      in_valid = v; in_op = op; in_data = d; in_cout = c; in_ovf = o;
      in_lt = lt; in_gt = gt; in_eq = eq; in_dest = dst;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (flags !== 7'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000000", flags); end
      checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", sticky_ovf); end
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal_op); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      set_in(1'b1, 3'b011, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
      tick();
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL single_data got %h exp 8000", out_data); end
      checks++; if (out_dest !== 4'h5) begin errors++; $display("FAIL single_dest got %h exp 5", out_dest); end
      checks++; if (flags !== 7'b0) begin errors++; $display("FAIL single_preflags got %b exp 0000000", flags); end
      tick();
      checks++; if (flags !== 7'b0110000) begin errors++; $display("FAIL single_flags got %b exp 0110000", flags); end
      checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL single_sticky got %b exp 1", sticky_ovf); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", out_valid); end
      checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL single_hold got %h exp 8000", out_data); end
   endtask

   task automatic test_fill();
      out_ready = 1'b0;
      set_in(1'b1, 3'b000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
      tick();
      set_in(1'b1, 3'b000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
      tick();
      set_in(1'b1, 3'b000, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got in_ready %b exp 0", in_ready); end
      tick();   // third push stalls
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      out_ready = 1'b1;
      checks++; if (out_data !== 16'h0001) begin errors++; $display("FAIL fill_pop1 got %h exp 0001", out_data); end
      tick();
      checks++; if (out_data !== 16'h0002 || out_valid !== 1'b1) begin errors++; $display("FAIL fill_pop2 got %h v%b exp 0002 v1", out_data, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drained got %b exp 0", out_valid); end
      checks++; if (flags !== 7'b0100000) begin errors++; $display("FAIL fill_flags got %b exp 0100000", flags); end
`ifdef ALU_RESULT_PERF_CNT_EN
      checks++; if (stall_cnt < 16'd1) begin errors++; $display("FAIL fill_stall_cnt got %0d exp >=1", stall_cnt); end
      checks++; if (retire_cnt !== 16'd3) begin errors++; $display("FAIL fill_retire_cnt got %0d exp 3", retire_cnt); end
`endif
   endtask

   task automatic test_full_pushpop();
      out_ready = 1'b0;
      set_in(1'b1, 3'b000, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA);
      tick();
      set_in(1'b1, 3'b000, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB);
      tick();
      set_in(1'b1, 3'b000, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC);
      out_ready = 1'b1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pp_full got in_ready %b exp 0", in_ready); end
      tick();
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL pp_count1 got rdy %b v %b exp 1 1", in_ready, out_valid); end
      checks++; if (out_data !== 16'h0020 || out_dest !== 4'hB) begin errors++; $display("FAIL pp_head got %h/%h exp 0020/b", out_data, out_dest); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_nopush got %b exp 0", out_valid); end
      checks++; if (flags !== 7'b0100010) begin errors++; $display("FAIL pp_flags got %b exp 0100010", flags); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b0;
      set_in(1'b1, 3'b110, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h7);
      tick();
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      checks++; if (out_data !== 16'h0000 || out_valid !== 1'b1) begin errors++; $display("FAIL ill_data got %h v%b exp 0000 v1", out_data, out_valid); end
      out_ready = 1'b1;
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_early got %b exp 0", illegal_op); end
      tick();
      checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_pulse got %b exp 1", illegal_op); end
      checks++; if (flags !== 7'b0100010) begin errors++; $display("FAIL ill_flags got %b exp 0100010", flags); end
      tick();
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_one_cycle got %b exp 0", illegal_op); end
   endtask

   task automatic test_sticky_branch();
      // sticky is 1 from test_single: clear it
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL stk_clear got %b exp 0", sticky_ovf); end
      out_ready = 1'b0;
      set_in(1'b1, 3'b100, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2);
      tick();
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      br_cond = 3'b010; out_ready = 1'b1; sticky_clr = 1'b1;
      #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_pre_retire got %b exp 0", br_taken); end
      tick();
      sticky_clr = 1'b0;
      checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL stk_set_wins got %b exp 1", sticky_ovf); end
      checks++; if (flags !== 7'b1101001) begin errors++; $display("FAIL op100_flags got %b exp 1101001", flags); end
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_eq got %b exp 1", br_taken); end
      br_cond = 3'b011; #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_neq got %b exp 0", br_taken); end
      br_cond = 3'b000; #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_never got %b exp 0", br_taken); end
      br_cond = 3'b001; #1;
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_always got %b exp 1", br_taken); end
      // op 101: only Z/LT/GT/EQ load
      set_in(1'b1, 3'b101, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3);
      tick();
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      checks++; if (flags !== 7'b1100100) begin errors++; $display("FAIL op101_flags got %b exp 1100100", flags); end
      br_cond = 3'b100; #1;
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_lt got %b exp 1", br_taken); end
      br_cond = 3'b101; #1;
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL br_nlt got %b exp 0", br_taken); end
      br_cond = 3'b111; #1;
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_ngt got %b exp 1", br_taken); end
      // op 010: C loads, V holds
      set_in(1'b1, 3'b010, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4);
      tick();
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      checks++; if (flags !== 7'b0110010) begin errors++; $display("FAIL op010_flags got %b exp 0110010", flags); end
      br_cond = 3'b110; #1;
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL br_gt got %b exp 1", br_taken); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      set_in(1'b1, 3'b011, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1);
      tick(); tick();
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      rst_n = 1'b0; out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
      checks++; if (flags !== 7'b0) begin errors++; $display("FAIL mid_rst_flags got %b exp 0000000", flags); end
      checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky got %b exp 0", sticky_ovf); end
      tick();
      checks++; if (flags !== 7'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_dropped got %b v%b exp 0000000 v0", flags, out_valid); end
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0; br_cond = 3'b000;
      set_in(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      #2;
      test_reset();
      test_single();
      test_fill();
      test_full_pushpop();
      test_illegal();
      test_sticky_branch();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
